// File: rtl/demap_pkg.sv
// Shared constants for the APSK demapper back end: Mode encodings, LLR widths
// and the Mode-to-bits-per-symbol lookup.
package demap_pkg;

  localparam int DEF_LLR_W   = 19;
  localparam int DEF_OUT_W   = 8;
  localparam int LLR_PER_SYM = 6;

  localparam logic [2:0] MODE_QPSK   = 3'd0;
  localparam logic [2:0] MODE_8PSK   = 3'd1;
  localparam logic [2:0] MODE_16APSK = 3'd2;
  localparam logic [2:0] MODE_32APSK = 3'd3;
  localparam logic [2:0] MODE_64APSK = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // Zero marks an illegal Mode (5..7).
  function automatic logic [2:0] bits_per_mode(input logic [2:0] mode);
    logic [2:0] n;
    case (mode)
      MODE_QPSK:   n = 3'd2;
      MODE_8PSK:   n = 3'd3;
      MODE_16APSK: n = 3'd4;
      MODE_32APSK: n = 3'd5;
      MODE_64APSK: n = 3'd6;
      default:     n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/llr_serializer_fifo.sv
// Symbol FIFO between demapper and serializer; holds whole symbols (6 LLRs + Mode).
// A push while full is accepted when a pop happens in the same cycle.
module llr_sym_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/llr_serializer.sv
// Serializes demapped symbols into one scaled/saturated LLR per handshake.
// Optional saturation statistics (sat_cnt port) are built when LLR_STATS_EN is defined.
module llr_serializer
  import demap_pkg::*;
#(
  parameter int LLR_W     = DEF_LLR_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int SHIFT     = 4,
  parameter int SYM_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [2:0]              in_mode,
  input  logic signed [LLR_W-1:0] in_llr_0,
  input  logic signed [LLR_W-1:0] in_llr_1,
  input  logic signed [LLR_W-1:0] in_llr_2,
  input  logic signed [LLR_W-1:0] in_llr_3,
  input  logic signed [LLR_W-1:0] in_llr_4,
  input  logic signed [LLR_W-1:0] in_llr_5,
  input  logic                    clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_llr,
  output logic                    out_last,
  output logic [2:0]              out_idx,
  output logic                    overflow,
  output logic                    mode_err
`ifdef LLR_STATS_EN
  ,
  output logic [15:0]             sat_cnt
`endif
);

  localparam int DATA_W = LLR_PER_SYM * LLR_W + 3;
  localparam logic signed [LLR_W-1:0] SAT_HI = LLR_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [LLR_W-1:0] SAT_LO = -SAT_HI;

  // Floor shift, then symmetric clip so the most negative code never appears.
  function automatic logic signed [OUT_W-1:0] sat_val(input logic signed [LLR_W-1:0] x);
    logic signed [LLR_W-1:0] v;
    v = x >>> SHIFT;
    if (v > SAT_HI)      return SAT_HI[OUT_W-1:0];
    else if (v < SAT_LO) return SAT_LO[OUT_W-1:0];
    else                 return v[OUT_W-1:0];
  endfunction

  ser_state_t              state;
  logic [DATA_W-1:0]       wr_data;
  logic [DATA_W-1:0]       rd_data;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    in_legal;
  logic                    ovf_evt;
  logic                    merr_evt;
  logic                    hs;
  logic                    adv;
  logic [2:0]              head_n;
  logic [2:0]              sym_n;
  logic [2:0]              nxt_idx;
  logic signed [LLR_W-1:0] sr [LLR_PER_SYM];
  logic signed [LLR_W-1:0] nxt_raw;
  logic signed [LLR_W-1:0] beat_raw;
  logic signed [OUT_W-1:0] beat_llr;

  // Output stream: a beat transfers on a rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready low, out_llr/out_last/out_idx are frozen.
  assign hs       = out_valid && out_ready;
  assign adv      = (state == ST_SEND) && hs && !out_last;
  assign pop      = !fifo_empty && ((state == ST_IDLE) || (hs && out_last));

  assign in_legal = (bits_per_mode(in_mode) != 3'd0);
  assign push     = in_valid && in_legal && (!fifo_full || pop);
  assign ovf_evt  = in_valid && in_legal && fifo_full && !pop;
  assign merr_evt = in_valid && !in_legal;

  assign wr_data  = {in_mode, in_llr_5, in_llr_4, in_llr_3, in_llr_2, in_llr_1, in_llr_0};
  assign head_n   = bits_per_mode(rd_data[DATA_W-1 -: 3]);
  assign nxt_idx  = out_idx + 3'd1;

  always_comb begin
    nxt_raw = sr[0];
    case (nxt_idx)
      3'd1:    nxt_raw = sr[1];
      3'd2:    nxt_raw = sr[2];
      3'd3:    nxt_raw = sr[3];
      3'd4:    nxt_raw = sr[4];
      3'd5:    nxt_raw = sr[5];
      default: nxt_raw = sr[0];
    endcase
  end

  assign beat_raw = pop ? rd_data[LLR_W-1:0] : nxt_raw;
  assign beat_llr = sat_val(beat_raw);

  llr_sym_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (SYM_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_llr   <= '0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      sym_n     <= '0;
      for (int i = 0; i < LLR_PER_SYM; i++) sr[i] <= '0;
    end else if (pop) begin
      // Load covers both the IDLE start and the bubble-free chain after a last beat.
      state     <= ST_SEND;
      out_valid <= 1'b1;
      out_llr   <= beat_llr;
      out_last  <= 1'b0;
      out_idx   <= '0;
      sym_n     <= head_n;
      for (int i = 0; i < LLR_PER_SYM; i++) sr[i] <= rd_data[i*LLR_W +: LLR_W];
    end else begin
      case (state)
        ST_IDLE: begin
          out_valid <= 1'b0;
        end
        ST_SEND: begin
          if (adv) begin
            out_llr  <= beat_llr;
            out_idx  <= nxt_idx;
            out_last <= (nxt_idx == sym_n - 3'd1);
          end else if (hs) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky flags: a new event in the same cycle as clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      mode_err <= 1'b0;
    end else begin
      if (ovf_evt)  overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
      if (merr_evt) mode_err <= 1'b1;
      else if (clr) mode_err <= 1'b0;
    end
  end

`ifdef LLR_STATS_EN
  function automatic logic is_clip(input logic signed [LLR_W-1:0] x);
    logic signed [LLR_W-1:0] v;
    v = x >>> SHIFT;
    return (v > SAT_HI) || (v < SAT_LO);
  endfunction

  logic out_clip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_clip <= 1'b0;
      sat_cnt  <= '0;
    end else begin
      if (pop || adv) out_clip <= is_clip(beat_raw);
      if (hs && out_clip) begin
        if (clr)                      sat_cnt <= 16'd1;
        else if (sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
      end else if (clr) begin
        sat_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_llr_serializer.sv
// Directed bench for llr_serializer: scoreboard of expected beats, monitor at negedge.
// Build with LLR_STATS_EN defined to also check sat_cnt.
module tb_llr_serializer;

  localparam int LLR_W = 19;
  localparam int OUT_W = 8;
  localparam int EW    = OUT_W + 4;

  logic                    clk;
  logic                    rst_n;
  logic                    in_valid;
  logic [2:0]              in_mode;
  logic signed [LLR_W-1:0] in_llr_0, in_llr_1, in_llr_2, in_llr_3, in_llr_4, in_llr_5;
  logic                    clr;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_llr;
  logic                    out_last;
  logic [2:0]              out_idx;
  logic                    overflow;
  logic                    mode_err;
`ifdef LLR_STATS_EN
  logic [15:0]             sat_cnt;
`endif

  logic [EW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cur[6];

  llr_serializer #(
    .LLR_W (LLR_W), .OUT_W (OUT_W), .SHIFT (4), .SYM_DEPTH (4)
  ) dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_mode (in_mode),
    .in_llr_0 (in_llr_0), .in_llr_1 (in_llr_1), .in_llr_2 (in_llr_2),
    .in_llr_3 (in_llr_3), .in_llr_4 (in_llr_4), .in_llr_5 (in_llr_5),
    .clr (clr), .out_valid (out_valid), .out_ready (out_ready),
    .out_llr (out_llr), .out_last (out_last), .out_idx (out_idx),
    .overflow (overflow), .mode_err (mode_err)
`ifdef LLR_STATS_EN
    , .sat_cnt (sat_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int scale_exp(input int llr);
    int v;
    if (llr >= 0) v = llr / 16;
    else          v = -((-llr + 15) / 16);
    if (v > 127)  v = 127;
    if (v < -127) v = -127;
    return v;
  endfunction

  function automatic int n_of_mode(input logic [2:0] mode);
    case (mode)
      3'd0: return 2;
      3'd1: return 3;
      3'd2: return 4;
      3'd3: return 5;
      3'd4: return 6;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic fill_rand();
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) cur[i] = int'($urandom_range(0, 4095)) - 2048;
      else                           cur[i] = int'($urandom_range(0, 524287)) - 262144;
    end
  endtask

  task automatic push_sym(input logic [2:0] mode, input bit accept);
    int n;
    in_mode  = mode;
    in_llr_0 = LLR_W'(cur[0]);
    in_llr_1 = LLR_W'(cur[1]);
    in_llr_2 = LLR_W'(cur[2]);
    in_llr_3 = LLR_W'(cur[3]);
    in_llr_4 = LLR_W'(cur[4]);
    in_llr_5 = LLR_W'(cur[5]);
    in_valid = 1'b1;
    if (accept) begin
      n = n_of_mode(mode);
      for (int i = 0; i < n; i++)
        exp_q.push_back({(i == n - 1), 3'(i), OUT_W'(scale_exp(cur[i]))});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid !== 1'b0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] obs;
    logic [EW-1:0] exp;
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      obs = {out_last, out_idx, out_llr};
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", obs, -1);
      end else if (out_ready === 1'b1) begin
        exp = exp_q.pop_front();
        chk("beat", obs, exp);
      end else begin
        exp = exp_q[0];
        chk("stall_hold", obs, exp);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    int cnt;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = '0;
    in_llr_0  = '0; in_llr_1 = '0; in_llr_2 = '0;
    in_llr_3  = '0; in_llr_4 = '0; in_llr_5 = '0;
    clr       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_llr",   out_llr,   0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_out_idx",   out_idx,   0);
    chk("rst_overflow",  overflow,  0);
    chk("rst_mode_err",  mode_err,  0);
`ifdef LLR_STATS_EN
    chk("rst_sat_cnt", sat_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Mode 4 reference symbol, ready high: also checks no-bypass latency
    out_ready = 1'b1;
    cur = '{1000, -5000, 2047, -17, 0, 2048};
    push_sym(3'd4, 1'b1);
    @(negedge clk);
    chk("no_bypass", out_valid, 0);
    @(negedge clk);
    chk("first_valid", out_valid, 1);
    wait_drain(50, "drain_mode4");
`ifdef LLR_STATS_EN
    chk("sat_cnt_two", sat_cnt, 2);
`endif

    // Mode 0 then Mode 1 back to back: 5 consecutive valid beats
    fill_rand();
    push_sym(3'd0, 1'b1);
    fill_rand();
    push_sym(3'd1, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (out_valid !== 1'b1 && k < 20);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid === 1'b1) cnt++;
      if (i < 4) @(negedge clk);
    end
    chk("no_bubble", cnt, 5);
    wait_drain(50, "drain_m0m1");

    // Illegal modes, clr, and set-wins-over-clr
    fill_rand();
    push_sym(3'd6, 1'b0);
    @(negedge clk);
    chk("mode_err_set", mode_err, 1);
    chk("mode6_no_out", out_valid, 0);
    pulse_clr();
    @(negedge clk);
    chk("mode_err_clr", mode_err, 0);
`ifdef LLR_STATS_EN
    chk("sat_cnt_clr", sat_cnt, 0);
`endif
    clr = 1'b1;
    push_sym(3'd7, 1'b0);
    clr = 1'b0;
    @(negedge clk);
    chk("set_wins_clr", mode_err, 1);
    pulse_clr();
    @(negedge clk);
    chk("mode_err_clr2", mode_err, 0);

    // Backpressure: 1 held + 4 buffered, 6th push overflows
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      fill_rand();
      push_sym(3'd4, 1'b1);
    end
    @(negedge clk);
    chk("no_overflow_5", overflow, 0);
    fill_rand();
    push_sym(3'd4, 1'b0);
    @(negedge clk);
    chk("overflow_6", overflow, 1);
    chk("held_valid", out_valid, 1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain(100, "drain_30");
    pulse_clr();
    @(negedge clk);
    chk("overflow_clr", overflow, 0);

    // Ready toggling every cycle on a Mode 2 symbol
    out_ready = 1'b0;
    fill_rand();
    push_sym(3'd2, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1 out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    wait_drain(50, "drain_toggle");

    // Reset in the middle of a symbol
    fill_rand();
    push_sym(3'd4, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!(out_valid === 1'b1 && out_idx == 3'd2) && k < 40);
    chk("reach_idx2", out_idx, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_idx",   out_idx,   0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill_rand();
    push_sym(3'd3, 1'b1);
    wait_drain(50, "drain_after_rst");
    chk("post_rst_overflow", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
